// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential shift-add multiplier with a start/busy/done handshake.
// Processes one multiplier bit per cycle and stops early once no set multiplier bits remain.
// Define SEQ_MULT_SIGNED_EN to treat a_i/b_i as two's complement; otherwise the design is unsigned only.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_d;
    logic               last;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_d;

    // Accumulator and multiplier after this CALC step; last marks the final step
    always_comb begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mplier_d = mplier_q >> 1;
        last     = (mplier_d == '0) || (cnt_q == CW'(WIDTH - 1));
    end

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;

    // Magnitudes fed to the unsigned core; the most negative value maps to 2^(WIDTH-1)
    always_comb begin
        a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
        b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
        prod_d = neg_q ? -acc_d : acc_d;
    end

    // Result sign captured with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            neg_q <= 1'b0;
        else if (state_q == IDLE && start_i)
            neg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end
`else
    // Unsigned operands pass straight through to the core
    always_comb begin
        a_mag  = a_i;
        b_mag  = b_i;
        prod_d = acc_d;
    end
`endif

    // Controller and datapath: capture in IDLE, shift-add in CALC, one-cycle pulse in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) begin
                        product_q <= prod_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
endmodule
